div_arbiter: RTL

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter_pkg.sv | 18 +
 rtl/div_arbiter_rr_picker.sv | 38 +++
 rtl/div_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arbiter_pkg;

   // Arbiter control states; one divide in flight at a time.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Default watchdog limit for a divide, in BUSY cycles.
   localparam int unsigned DEFAULT_TIMEOUT = 64;

   // Width of the BUSY cycle counter.
   localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/div_arbiter_rr_picker.sv
// Round-robin picker: first set request at or above the pointer, with wrap.
module rr_picker #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [N-1:0] w_rot;
   int unsigned  w_sum;

   // Rotate requests so the pointer lands at bit 0, then take the lowest set bit.
   always_comb begin
      w_rot   = N'({i_req, i_req} >> i_ptr);
      w_sum   = 0;
      o_any   = 1'b0;
      o_idx   = '0;
      o_grant = '0;
      for (int k = 0; k < N; k++) begin
         if (!o_any && w_rot[k]) begin
            o_any = 1'b1;
            w_sum = 32'(i_ptr) + 32'(k);
            if (w_sum >= N) begin
               w_sum = w_sum - N;
            end
            o_idx = IW'(w_sum);
         end
      end
      if (o_any) begin
         o_grant = N'(1) << o_idx;
      end
   end

endmodule

// File: rtl/div_arbiter.sv
// Arbitrates N requesters onto one shared iterative divider, one divide at a time.
module div_arbiter
   import div_arbiter_pkg::*;
#(
   parameter int unsigned W       = 32,
   parameter int unsigned N       = 4,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N-1:0]           req_valid,
   output logic [N-1:0]           req_ready,
   input  logic [N*W-1:0]         req_left,
   input  logic [N*W-1:0]         req_right,
   output logic                   div_go,
   output logic [W-1:0]           div_left,
   output logic [W-1:0]           div_right,
   input  logic [W-1:0]           div_quotient,
   input  logic [W-1:0]           div_remainder,
   input  logic                   div_done,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [$clog2(N)-1:0]   resp_id,
   output logic [W-1:0]           resp_quotient,
   output logic [W-1:0]           resp_remainder,
   output logic                   resp_dbz,
   output logic                   resp_err
);

   localparam int unsigned IW = $clog2(N);

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_ptr;
   logic [W-1:0]    r_left;
   logic [W-1:0]    r_right;
   logic [CNT_W-1:0] r_cnt;
   logic [IW-1:0]   r_id;
   logic [W-1:0]    r_q;
   logic [W-1:0]    r_r;
   logic            r_dbz;
   logic            r_err;

   logic [N-1:0]    w_grant;
   logic [IW-1:0]   w_idx;
   logic            w_any;
   logic            w_accept;
   logic [N-1:0]    w_ready;
   logic            w_timeout;
   logic [IW-1:0]   w_ptr_next;
   logic [W-1:0]    w_left_arr  [N];
   logic [W-1:0]    w_right_arr [N];
   logic [W-1:0]    w_sel_left;
   logic [W-1:0]    w_sel_right;

   // Grant selection from the rotating pointer.
   rr_picker #(
      .N  (N),
      .IW (IW)
   ) u_picker (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Unpack the flattened operand buses into per-requester lanes.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_left_arr[i]  = req_left[i*W +: W];
         w_right_arr[i] = req_right[i*W +: W];
      end
   end

   assign w_sel_left  = w_left_arr[w_idx];
   assign w_sel_right = w_right_arr[w_idx];
   assign w_ptr_next  = (w_idx == IW'(N - 1)) ? '0 : w_idx + IW'(1);
   assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));

   // Next-state and accept decode.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_ready  = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_accept = 1'b1;
               w_ready  = w_grant;
               w_next   = (w_sel_right == '0) ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: w_next = ST_BUSY;
         ST_BUSY: begin
            if (div_done || w_timeout) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Operand capture, BUSY watchdog and response payload registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr   <= '0;
         r_left  <= '0;
         r_right <= '0;
         r_cnt   <= '0;
         r_id    <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_dbz   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_ptr   <= w_ptr_next;
            r_left  <= w_sel_left;
            r_right <= w_sel_right;
            r_id    <= w_idx;
            if (w_sel_right == '0) begin
               // Divide by zero never reaches the divider.
               r_q   <= '1;
               r_r   <= w_sel_left;
               r_dbz <= 1'b1;
               r_err <= 1'b0;
            end
         end
         if (r_state == ST_ISSUE) begin
            r_cnt <= '0;
         end
         if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (div_done) begin
               r_q   <= div_quotient;
               r_r   <= div_remainder;
               r_dbz <= 1'b0;
               r_err <= 1'b0;
            end else if (w_timeout) begin
               r_q   <= '0;
               r_r   <= '0;
               r_dbz <= 1'b0;
               r_err <= 1'b1;
            end
         end
      end
   end

   assign req_ready      = w_ready;
   assign div_go         = (r_state == ST_ISSUE);
   assign div_left       = r_left;
   assign div_right      = r_right;
   assign resp_valid     = (r_state == ST_RESP);
   assign resp_id        = r_id;
   assign resp_quotient  = r_q;
   assign resp_remainder = r_r;
   assign resp_dbz       = r_dbz;
   assign resp_err       = r_err;

endmodule
